// File: rtl/afc_start_sequencer_if.sv
// AFC start/busy handshake between the PLL-core sequencer (master) and the
// TMR AFC FSM (slave). The master raises AFCstart, the slave answers on AFCbusy.
interface afc_start_sequencer_if;
  logic AFCstart;
  logic AFCbusy;

  modport master (output AFCstart, input AFCbusy);
  modport slave  (input AFCstart, output AFCbusy);
endinterface

// File: rtl/afc_start_sequencer.sv
// Initiator side of the AFC start/busy handshake, clocked by ckref.
// Waits for the VCO to settle, pulses AFCstart, then follows AFCbusy to
// completion, with ack/completion timeouts and bounded retries.
// Optional feature macro: AFC_SEQ_LOCK_MONITOR_EN enables automatic
// recalibration on filtered loss of pll_locked while LOCKED (and relock_cnt).
module afc_start_sequencer #(
  parameter int STARTUP_WAIT     = 1024,
  parameter int START_PULSE_LEN  = 4,
  parameter int BUSY_ACK_TIMEOUT = 64,
  parameter int CAL_TIMEOUT      = 65535,
  parameter int MAX_RETRY        = 3,
  parameter int LOSS_FILTER      = 16
) (
  input  logic                        ckref,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        recal_req,
  input  logic                        overridecontrol,
  input  logic                        pll_locked,
  afc_start_sequencer_if.master       afc,
  output logic                        cal_done,
  output logic                        cal_fail,
  output logic [1:0]                  retry_cnt,
  output logic [3:0]                  relock_cnt,
  output logic [2:0]                  seq_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    LOCKED    = 3'd5,
    FAIL      = 3'd6
  } seqState_t;

  // Timer reload values: every phase counts down to 0, so load N-1 for N cycles.
  localparam logic [15:0] SETTLE_LOAD = 16'(STARTUP_WAIT - 1);
  localparam logic [15:0] PULSE_LOAD  = 16'(START_PULSE_LEN - 1);
  localparam logic [15:0] ACK_LOAD    = 16'(BUSY_ACK_TIMEOUT - 1);
  localparam logic [15:0] CAL_LOAD    = 16'(CAL_TIMEOUT - 1);
  localparam logic [1:0]  RETRY_LAST  = 2'(MAX_RETRY);

  seqState_t   state;
  logic [15:0] timer;

`ifdef AFC_SEQ_LOCK_MONITOR_EN
  localparam logic [5:0] LOSS_LAST = 6'(LOSS_FILTER - 1);
  logic [5:0] lossCnt;
  logic [3:0] relockCnt;
  assign relock_cnt = relockCnt;
`else
  // Lock monitor absent: pll_locked and the filter length are deliberately unused.
  logic [6:0] unusedLockInputs;
  assign unusedLockInputs = {pll_locked, 6'(LOSS_FILTER)};
  assign relock_cnt = 4'd0;
`endif

  assign seq_state = state;

  // Sequencer FSM: state, timer and all registered outputs in one block.
  always_ff @(posedge ckref) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= 16'd0;
      afc.AFCstart <= 1'b0;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
      retry_cnt    <= 2'd0;
`ifdef AFC_SEQ_LOCK_MONITOR_EN
      lossCnt      <= 6'd0;
      relockCnt    <= 4'd0;
`endif
    end else if (!enable || overridecontrol) begin
      // Disabled or under SPI override: park in IDLE, drop the handshake and flags.
      state        <= IDLE;
      timer        <= 16'd0;
      afc.AFCstart <= 1'b0;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
`ifdef AFC_SEQ_LOCK_MONITOR_EN
      lossCnt      <= 6'd0;
`endif
    end else begin
`ifdef AFC_SEQ_LOCK_MONITOR_EN
      // Loss counter only survives while LOCKED with the lock indicator low.
      lossCnt <= 6'd0;
`endif
      case (state)
        IDLE: begin
          state     <= SETTLE;
          timer     <= SETTLE_LOAD;
          retry_cnt <= 2'd0;
        end
        SETTLE: begin
          if (timer == 16'd0) begin
            state        <= START;
            timer        <= PULSE_LOAD;
            afc.AFCstart <= 1'b1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        START: begin
          if (timer == 16'd0) begin
            state        <= WAIT_BUSY;
            timer        <= ACK_LOAD;
            afc.AFCstart <= 1'b0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        WAIT_BUSY: begin
          if (afc.AFCbusy) begin
            state <= WAIT_DONE;
            timer <= CAL_LOAD;
          end else if (timer == 16'd0) begin
            if (retry_cnt == RETRY_LAST) begin
              state    <= FAIL;
              cal_fail <= 1'b1;
            end else begin
              state     <= SETTLE;
              timer     <= SETTLE_LOAD;
              retry_cnt <= retry_cnt + 2'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!afc.AFCbusy) begin
            state    <= LOCKED;
            cal_done <= 1'b1;
          end else if (timer == 16'd0) begin
            if (retry_cnt == RETRY_LAST) begin
              state    <= FAIL;
              cal_fail <= 1'b1;
            end else begin
              state     <= SETTLE;
              timer     <= SETTLE_LOAD;
              retry_cnt <= retry_cnt + 2'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        LOCKED: begin
          if (recal_req) begin
            state     <= SETTLE;
            timer     <= SETTLE_LOAD;
            cal_done  <= 1'b0;
            cal_fail  <= 1'b0;
            retry_cnt <= 2'd0;
          end
`ifdef AFC_SEQ_LOCK_MONITOR_EN
          else if (!pll_locked) begin
            if (lossCnt == LOSS_LAST) begin
              state     <= SETTLE;
              timer     <= SETTLE_LOAD;
              cal_done  <= 1'b0;
              retry_cnt <= 2'd0;
              if (relockCnt != 4'd15) begin
                relockCnt <= relockCnt + 4'd1;
              end
            end else begin
              lossCnt <= lossCnt + 6'd1;
            end
          end
`endif
        end
        FAIL: begin
          if (recal_req) begin
            state     <= SETTLE;
            timer     <= SETTLE_LOAD;
            cal_done  <= 1'b0;
            cal_fail  <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end
        default: begin
          state        <= IDLE;
          timer        <= 16'd0;
          afc.AFCstart <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afc_start_sequencer.sv
// Directed bench for afc_start_sequencer with short timing parameters.
// Lock-monitor checks follow AFC_SEQ_LOCK_MONITOR_EN, matching the DUT build.
module tb_afc_start_sequencer;
  logic       ckref = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       recal_req = 1'b0;
  logic       overridecontrol = 1'b0;
  logic       pll_locked = 1'b1;
  logic       cal_done;
  logic       cal_fail;
  logic [1:0] retry_cnt;
  logic [3:0] relock_cnt;
  logic [2:0] seq_state;

  int checks = 0;
  int failures = 0;

  afc_start_sequencer_if afcIf ();

  afc_start_sequencer #(
    .STARTUP_WAIT    (8),
    .START_PULSE_LEN (4),
    .BUSY_ACK_TIMEOUT(6),
    .CAL_TIMEOUT     (20),
    .MAX_RETRY       (2),
    .LOSS_FILTER     (16)
  ) dut (
    .ckref          (ckref),
    .reset          (reset),
    .enable         (enable),
    .recal_req      (recal_req),
    .overridecontrol(overridecontrol),
    .pll_locked     (pll_locked),
    .afc            (afcIf),
    .cal_done       (cal_done),
    .cal_fail       (cal_fail),
    .retry_cnt      (retry_cnt),
    .relock_cnt     (relock_cnt),
    .seq_state      (seq_state)
  );

  always #5 ckref = ~ckref;

  // One line per comparison; mismatches also bump the failure count.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge ckref);
    #1;
  endtask

  task automatic waitStartRise(input int limit, output int n);
    n = 0;
    while (afcIf.AFCstart !== 1'b1 && n <= limit) begin
      tick();
      n++;
    end
  endtask

  task automatic waitStartFall(input int limit, output int n);
    n = 0;
    while (afcIf.AFCstart !== 1'b0 && n <= limit) begin
      tick();
      n++;
    end
  endtask

  // From anywhere before the pulse: answer the start with a short busy burst.
  task automatic runToLocked();
    int n;
    waitStartRise(40, n);
    checkVal("rtl_start_seen", 32'(n <= 40), 1);
    waitStartFall(10, n);
    afcIf.AFCbusy = 1'b1;
    tick();
    tick();
    afcIf.AFCbusy = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] startPattern;
    int          riseTick [3];
    int          riseCount;
    logic        prevStart;
    logic        anyStart;
    int          n;

    afcIf.AFCbusy = 1'b0;
    startPattern = 32'd0;

    // Reset state
    repeat (3) tick();
    checkVal("rst_state", seq_state, 0);
    checkVal("rst_afcstart", afcIf.AFCstart, 0);
    checkVal("rst_cal_done", cal_done, 0);
    checkVal("rst_cal_fail", cal_fail, 0);
    checkVal("rst_retry", retry_cnt, 0);
    checkVal("rst_relock", relock_cnt, 0);
    reset = 1'b1;
    tick();
    checkVal("idle_disabled", seq_state, 0);

    // Test 1: nominal calibration, busy 2 cycles after pulse end, held 10 cycles
    enable = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t <= 16) startPattern[t] = afcIf.AFCstart;
      if (t == 14) begin
        checkVal("t1_state_wait_busy", seq_state, 3);
        afcIf.AFCbusy = 1'b1;
      end
      if (t == 15) checkVal("t1_state_wait_done", seq_state, 4);
      if (t == 24) afcIf.AFCbusy = 1'b0;
    end
    checkVal("t1_start_pattern", startPattern, 32'h0000_1E00);
    checkVal("t1_state_locked", seq_state, 5);
    checkVal("t1_cal_done", cal_done, 1);
    checkVal("t1_cal_fail", cal_fail, 0);
    checkVal("t1_retry", retry_cnt, 0);

`ifdef AFC_SEQ_LOCK_MONITOR_EN
    // Test 6: filtered lock loss and relock_cnt saturation
    pll_locked = 1'b0;
    repeat (15) tick();
    checkVal("t6_15_low_stays_locked", seq_state, 5);
    pll_locked = 1'b1;
    tick();
    pll_locked = 1'b0;
    repeat (16) tick();
    pll_locked = 1'b1;
    checkVal("t6_16_low_state", seq_state, 1);
    checkVal("t6_16_low_relock", relock_cnt, 1);
    checkVal("t6_16_low_cal_done", cal_done, 0);
    for (int e = 2; e <= 16; e++) begin
      runToLocked();
      checkVal("t6_relocked", seq_state, 5);
      pll_locked = 1'b0;
      repeat (16) tick();
      pll_locked = 1'b1;
    end
    checkVal("t6_relock_saturated", relock_cnt, 15);
`else
    // Without the lock monitor, pll_locked has no effect in LOCKED
    pll_locked = 1'b0;
    repeat (20) tick();
    checkVal("nolm_stays_locked", seq_state, 5);
    checkVal("nolm_relock", relock_cnt, 0);
    pll_locked = 1'b1;
`endif

    // Test 2: busy never rises -> three pulses 18 cycles apart, then FAIL
    enable = 1'b0;
    tick();
    checkVal("t2_disable_state", seq_state, 0);
    checkVal("t2_disable_cal_done", cal_done, 0);
    enable = 1'b1;
    afcIf.AFCbusy = 1'b0;
    riseCount = 0;
    riseTick[0] = 0;
    riseTick[1] = 0;
    riseTick[2] = 0;
    prevStart = afcIf.AFCstart;
    for (int t = 1; t <= 55; t++) begin
      tick();
      if (afcIf.AFCstart && !prevStart) begin
        if (riseCount < 3) riseTick[riseCount] = t;
        riseCount++;
      end
      prevStart = afcIf.AFCstart;
      if (t == 54) checkVal("t2_last_wait_busy", seq_state, 3);
    end
    checkVal("t2_pulse_count", riseCount, 3);
    checkVal("t2_rise0", riseTick[0], 9);
    checkVal("t2_rise1", riseTick[1], 27);
    checkVal("t2_rise2", riseTick[2], 45);
    checkVal("t2_state_fail", seq_state, 6);
    checkVal("t2_cal_fail", cal_fail, 1);
    checkVal("t2_retry", retry_cnt, 2);
    checkVal("t2_cal_done", cal_done, 0);

    // Test 3: busy stuck high -> completion timeouts, FAIL, then recal_req
    enable = 1'b0;
    tick();
    enable = 1'b1;
    afcIf.AFCbusy = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 13) checkVal("t3_busy_in_start_ignored", seq_state, 3);
      if (t == 14) checkVal("t3_wait_done", seq_state, 4);
      if (t == 33) checkVal("t3_before_timeout", seq_state, 4);
      if (t == 34) begin
        checkVal("t3_retry1_state", seq_state, 1);
        checkVal("t3_retry1_cnt", retry_cnt, 1);
      end
    end
    checkVal("t3_state_fail", seq_state, 6);
    checkVal("t3_cal_fail", cal_fail, 1);
    checkVal("t3_retry", retry_cnt, 2);
    afcIf.AFCbusy = 1'b0;
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    checkVal("t3_recal_state", seq_state, 1);
    checkVal("t3_recal_cal_fail", cal_fail, 0);
    checkVal("t3_recal_cal_done", cal_done, 0);
    checkVal("t3_recal_retry", retry_cnt, 0);

    // Test 4: disable mid-pulse, override blocks start from IDLE
    waitStartRise(20, n);
    checkVal("t4_settle_len", n, 8);
    tick();
    enable = 1'b0;
    tick();
    checkVal("t4_abort_afcstart", afcIf.AFCstart, 0);
    checkVal("t4_abort_state", seq_state, 0);
    overridecontrol = 1'b1;
    enable = 1'b1;
    anyStart = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      anyStart = anyStart | afcIf.AFCstart | (seq_state != 3'd0);
    end
    checkVal("t4_override_blocks", anyStart, 0);
    overridecontrol = 1'b0;
    tick();
    checkVal("t4_override_release", seq_state, 1);

    // Test 5: reset during WAIT_DONE, then a full settle before the next pulse
    waitStartRise(20, n);
    waitStartFall(10, n);
    afcIf.AFCbusy = 1'b1;
    tick();
    tick();
    checkVal("t5_in_wait_done", seq_state, 4);
    reset = 1'b0;
    tick();
    checkVal("t5_rst_state", seq_state, 0);
    checkVal("t5_rst_afcstart", afcIf.AFCstart, 0);
    checkVal("t5_rst_cal_done", cal_done, 0);
    checkVal("t5_rst_cal_fail", cal_fail, 0);
    checkVal("t5_rst_retry", retry_cnt, 0);
    checkVal("t5_rst_relock", relock_cnt, 0);
    reset = 1'b1;
    afcIf.AFCbusy = 1'b0;
    waitStartRise(40, n);
    checkVal("t5_first_start_tick", n, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
